// File: rtl/m_mem_arbiter_if.sv
// Bundle of the fetch port, the data port and the single RAM port shared by m_mem_arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the RAM.
interface m_mem_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 32
);
  // Handshake: a requester raises req with addr/we/wdata and keeps them stable until it
  // sees gnt high in the same cycle (gnt is combinational). Dropping req before gnt means
  // no access. A granted read returns exactly one rvalid/rdata pulse in the next cycle.
  logic          w_if_req;
  logic [AW-1:0] w_if_addr;
  logic          w_if_gnt;
  logic          w_if_rvalid;
  logic [DW-1:0] w_if_rdata;

  logic          w_d_req;
  logic          w_d_we;
  logic [AW-1:0] w_d_addr;
  logic [DW-1:0] w_d_wdata;
  logic          w_d_gnt;
  logic          w_d_rvalid;
  logic [DW-1:0] w_d_rdata;

  logic [AW-1:0] w_m_addr;
  logic          w_m_we;
  logic [DW-1:0] w_m_din;
  logic [DW-1:0] w_m_dout;

  logic [1:0]    w_dbg_own;

  modport slave (
    input  w_if_req, w_if_addr,
    output w_if_gnt, w_if_rvalid, w_if_rdata,
    input  w_d_req, w_d_we, w_d_addr, w_d_wdata,
    output w_d_gnt, w_d_rvalid, w_d_rdata,
    output w_m_addr, w_m_we, w_m_din,
    input  w_m_dout,
    output w_dbg_own
  );

  modport master (
    output w_if_req, w_if_addr,
    input  w_if_gnt, w_if_rvalid, w_if_rdata,
    output w_d_req, w_d_we, w_d_addr, w_d_wdata,
    input  w_d_gnt, w_d_rvalid, w_d_rdata,
    input  w_m_addr, w_m_we, w_m_din,
    output w_m_dout,
    input  w_dbg_own
  );
endinterface

// File: rtl/m_mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data load/store; data has priority.
// Define ARB_FAIR_EN to compile in the fetch aging counter (forces a fetch win after STARVE_MAX denials).
module m_mem_arbiter #(
  parameter int AW         = 11,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic         w_clk,
  input  logic         w_rst,
  m_mem_arbiter_if.slave bus
);
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("m_mem_arbiter: STARVE_MAX must be in 1..15");
  end

  logic [1:0]    r_own;
  logic          w_starve_fire;
  logic          w_if_gnt;
  logic          w_d_gnt;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_dout;

`ifdef ARB_FAIR_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  logic [3:0] r_starve;

  assign w_starve_fire = bus.w_if_req && (r_starve == STARVE_LIM);

  // Counts consecutive denied fetch cycles; any fetch grant or idle fetch restarts it.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_starve <= 4'd0;
    end else if (!bus.w_if_req || w_if_gnt) begin
      r_starve <= 4'd0;
    end else if (r_starve != STARVE_LIM) begin
      r_starve <= r_starve + 4'd1;
    end
  end
`else
  assign w_starve_fire = 1'b0;
`endif

  // Grants are forced low while reset is high so a write racing reset never reaches the RAM.
  assign w_d_gnt  = !w_rst && bus.w_d_req && !w_starve_fire;
  assign w_if_gnt = !w_rst && bus.w_if_req && (!bus.w_d_req || w_starve_fire);

  assign w_addr       = w_d_gnt ? bus.w_d_addr : bus.w_if_addr;
  assign bus.w_m_addr = w_addr;
  assign bus.w_m_we   = w_d_gnt && bus.w_d_we;
  assign bus.w_m_din  = bus.w_d_wdata;
  assign bus.w_if_gnt = w_if_gnt;
  assign bus.w_d_gnt  = w_d_gnt;

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      r_own <= OWN_NONE;
    end else if (w_if_gnt) begin
      r_own <= OWN_IF;
    end else if (w_d_gnt && !bus.w_d_we) begin
      r_own <= OWN_D;
    end else begin
      r_own <= OWN_NONE;
    end
  end

  // The RAM output is shared; only the owning port sees it, the other reads zero.
  assign w_dout          = bus.w_m_dout;
  assign bus.w_if_rvalid = (r_own == OWN_IF);
  assign bus.w_d_rvalid  = (r_own == OWN_D);
  assign bus.w_if_rdata  = (r_own == OWN_IF) ? w_dout : '0;
  assign bus.w_d_rdata   = (r_own == OWN_D)  ? w_dout : '0;
  assign bus.w_dbg_own   = r_own;
endmodule

// File: tb/tb_m_mem_arbiter.sv
// Directed bench for m_mem_arbiter with a 1-cycle registered RAM model behind the shared port.
// Starvation expectations follow ARB_FAIR_EN (STARVE_MAX=4).
module tb_m_mem_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [DW-1:0] exp_q[$];

  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] mem [0:2047];

  m_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  m_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .w_clk (clk),
    .w_rst (rst),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM model ----------------
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.w_m_we) mem[bus.w_m_addr] <= bus.w_m_din;
    bus.w_m_dout <= mem[bus.w_m_addr];
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_rd(input string tag, input logic [DW-1:0] obs);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, obs, e);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic idle();
    bus.w_if_req   = 1'b0;
    bus.w_if_addr  = '0;
    bus.w_d_req    = 1'b0;
    bus.w_d_we     = 1'b0;
    bus.w_d_addr   = '0;
    bus.w_d_wdata  = '0;
  endtask

  task automatic drive_if(input logic [AW-1:0] a);
    bus.w_if_req  = 1'b1;
    bus.w_if_addr = a;
  endtask

  task automatic drive_d(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    bus.w_d_req   = 1'b1;
    bus.w_d_we    = we;
    bus.w_d_addr  = a;
    bus.w_d_wdata = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    next_cycle();
    pre_we   = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    rst = 1'b1;
    idle();
    // Requests during reset must not be granted, and the write must not reach the RAM.
    drive_if(11'd5);
    drive_d(1'b1, 11'd9, 32'hAAAA_AAAA);
    preload(11'd5, 32'hDEAD_BEEF);
    preload(11'd3, 32'h3333_3333);
    preload(11'd7, 32'h7777_7777);
    preload(11'd9, 32'h0000_0000);
    @(negedge clk);
    check("rst_if_gnt",    {31'd0, bus.w_if_gnt},    32'd0);
    check("rst_d_gnt",     {31'd0, bus.w_d_gnt},     32'd0);
    check("rst_m_we",      {31'd0, bus.w_m_we},      32'd0);
    check("rst_if_rvalid", {31'd0, bus.w_if_rvalid}, 32'd0);
    check("rst_d_rvalid",  {31'd0, bus.w_d_rvalid},  32'd0);
    check("rst_if_rdata",  bus.w_if_rdata,           32'd0);
    check("rst_d_rdata",   bus.w_d_rdata,            32'd0);
    check("rst_own",       {30'd0, bus.w_dbg_own},   32'd0);
    idle();
    next_cycle();
    rst = 1'b0;

    // Fetch-only read of address 5.
    drive_if(11'd5);
    @(negedge clk);
    check("fo_if_gnt", {31'd0, bus.w_if_gnt}, 32'd1);
    check("fo_d_gnt",  {31'd0, bus.w_d_gnt},  32'd0);
    check("fo_m_addr", {21'd0, bus.w_m_addr}, 32'd5);
    check("fo_m_we",   {31'd0, bus.w_m_we},   32'd0);
    exp_q.push_back(32'hDEAD_BEEF);
    next_cycle();
    idle();
    @(negedge clk);
    check("fo_if_rvalid", {31'd0, bus.w_if_rvalid}, 32'd1);
    check_rd("fo_if_rdata", bus.w_if_rdata);
    check("fo_d_rvalid",  {31'd0, bus.w_d_rvalid},  32'd0);
    check("fo_d_rdata",   bus.w_d_rdata,            32'd0);
    check("fo_own",       {30'd0, bus.w_dbg_own},   32'd1);
    next_cycle();

    // Collision: data read of 7 wins, fetch of 3 follows.
    drive_if(11'd3);
    drive_d(1'b0, 11'd7, 32'h0);
    @(negedge clk);
    check("col0_d_gnt",  {31'd0, bus.w_d_gnt},  32'd1);
    check("col0_if_gnt", {31'd0, bus.w_if_gnt}, 32'd0);
    check("col0_m_addr", {21'd0, bus.w_m_addr}, 32'd7);
    exp_q.push_back(32'h7777_7777);
    next_cycle();
    bus.w_d_req = 1'b0;
    @(negedge clk);
    check("col1_d_rvalid", {31'd0, bus.w_d_rvalid}, 32'd1);
    check_rd("col1_d_rdata", bus.w_d_rdata);
    check("col1_if_gnt",   {31'd0, bus.w_if_gnt},   32'd1);
    check("col1_m_addr",   {21'd0, bus.w_m_addr},   32'd3);
    exp_q.push_back(32'h3333_3333);
    next_cycle();
    idle();
    @(negedge clk);
    check("col2_if_rvalid", {31'd0, bus.w_if_rvalid}, 32'd1);
    check_rd("col2_if_rdata", bus.w_if_rdata);
    check("col2_d_rvalid",  {31'd0, bus.w_d_rvalid},  32'd0);
    next_cycle();

    // Write 0x1234 to 9, read it back next cycle.
    drive_d(1'b1, 11'd9, 32'h0000_1234);
    @(negedge clk);
    check("wr0_d_gnt",    {31'd0, bus.w_d_gnt},    32'd1);
    check("wr0_m_we",     {31'd0, bus.w_m_we},     32'd1);
    check("wr0_m_din",    bus.w_m_din,             32'h0000_1234);
    check("wr0_d_rvalid", {31'd0, bus.w_d_rvalid}, 32'd0);
    next_cycle();
    drive_d(1'b0, 11'd9, 32'h0000_5678);
    @(negedge clk);
    check("wr1_d_rvalid", {31'd0, bus.w_d_rvalid}, 32'd0);
    check("wr1_m_we",     {31'd0, bus.w_m_we},     32'd0);
    check("wr1_m_din",    bus.w_m_din,             32'h0000_5678);
    exp_q.push_back(32'h0000_1234);
    next_cycle();
    idle();
    @(negedge clk);
    check("wr2_d_rvalid", {31'd0, bus.w_d_rvalid}, 32'd1);
    check_rd("wr2_d_rdata", bus.w_d_rdata);
    check("wr2_if_rdata", bus.w_if_rdata,          32'd0);
    next_cycle();

    // Starvation: both requesters held continuously.
    drive_if(11'd3);
    drive_d(1'b0, 11'd7, 32'h0);
`ifdef ARB_FAIR_EN
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      check($sformatf("stv%0d_if_gnt", c), {31'd0, bus.w_if_gnt}, (c % 5 == 4) ? 32'd1 : 32'd0);
      check($sformatf("stv%0d_d_gnt", c),  {31'd0, bus.w_d_gnt},  (c % 5 == 4) ? 32'd0 : 32'd1);
      next_cycle();
    end
`else
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check($sformatf("stv%0d_if_gnt", c), {31'd0, bus.w_if_gnt}, 32'd0);
      check($sformatf("stv%0d_d_gnt", c),  {31'd0, bus.w_d_gnt},  32'd1);
      next_cycle();
    end
`endif
    idle();
    next_cycle();
    next_cycle();

    // Async reset pulsed between edges while a fetch read is in flight.
    drive_if(11'd5);
    @(negedge clk);
    check("ar0_if_gnt", {31'd0, bus.w_if_gnt}, 32'd1);
    @(posedge clk);
    #1;
    idle();
    #2;
    rst = 1'b1;
    #1;
    check("ar_if_rvalid_now", {31'd0, bus.w_if_rvalid}, 32'd0);
    check("ar_if_rdata_now",  bus.w_if_rdata,           32'd0);
    drive_if(11'd3);
    drive_d(1'b1, 11'd9, 32'hFFFF_FFFF);
    @(negedge clk);
    check("ar_if_gnt",    {31'd0, bus.w_if_gnt},    32'd0);
    check("ar_d_gnt",     {31'd0, bus.w_d_gnt},     32'd0);
    check("ar_m_we",      {31'd0, bus.w_m_we},      32'd0);
    check("ar_if_rvalid", {31'd0, bus.w_if_rvalid}, 32'd0);
    next_cycle();
    rst = 1'b0;
    idle();
    drive_if(11'd5);
    @(negedge clk);
    check("ar1_if_gnt",    {31'd0, bus.w_if_gnt},    32'd1);
    check("ar1_if_rvalid", {31'd0, bus.w_if_rvalid}, 32'd0);
    exp_q.push_back(32'hDEAD_BEEF);
    next_cycle();
    // Address 9 must still hold 0x1234: the write raised during reset never landed.
    idle();
    drive_d(1'b0, 11'd9, 32'h0);
    @(negedge clk);
    check("ar2_if_rvalid", {31'd0, bus.w_if_rvalid}, 32'd1);
    check_rd("ar2_if_rdata", bus.w_if_rdata);
    check("ar2_d_gnt",     {31'd0, bus.w_d_gnt},     32'd1);
    exp_q.push_back(32'h0000_1234);
    next_cycle();
    idle();
    @(negedge clk);
    check("ar3_d_rvalid", {31'd0, bus.w_d_rvalid}, 32'd1);
    check_rd("ar3_d_rdata", bus.w_d_rdata);
    check("ar3_if_rvalid", {31'd0, bus.w_if_rvalid}, 32'd0);
    next_cycle();

    check("exp_q_drained", exp_q.size(), 32'd0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/m_mem_arbiter.md
# m_mem_arbiter

Single-port memory arbiter that shares one m_memory-style RAM between the instruction-fetch requester and the data (load/store) requester of the pipelined core. It is placed between the two pipeline ports and one RAM instance, so one 2048-word array holds both program and data. Grants are issued combinationally in the request cycle. Read responses are routed back to the owning port one cycle later. An optional aging counter prevents fetch starvation.

## Interface
Parameters:
- AW, 11, RAM word-address width.
- DW, 32, data width.
- STARVE_MAX, 4, number of consecutive denied fetch cycles before fetch is forced to win. Used only with ARB_FAIR_EN. Legal range 1..15.

Ports:
- w_clk  in  1  clock; all state updates on posedge.
- w_rst  in  1  reset, asynchronous, active-high.
- w_if_req  in  1  fetch read request.
- w_if_addr  in  AW  fetch word address.
- w_if_gnt  out  1  fetch granted this cycle (combinational).
- w_if_rvalid  out  1  fetch read data valid (registered).
- w_if_rdata  out  DW  fetch read data.
- w_d_req  in  1  data request.
- w_d_we  in  1  data write enable; 0 means read.
- w_d_addr  in  AW  data word address.
- w_d_wdata  in  DW  store data.
- w_d_gnt  out  1  data granted this cycle (combinational).
- w_d_rvalid  out  1  data read data valid (registered).
- w_d_rdata  out  DW  data read data.
- w_m_addr  out  AW  RAM address.
- w_m_we  out  1  RAM write enable.
- w_m_din  out  DW  RAM write data.
- w_m_dout  in  DW  RAM read data, registered inside the RAM (1-cycle latency).

## Operation
- Winner selection per cycle:
  - Data has priority by default.
  - Fetch wins when only fetch requests, or when the starve rule fires (ARB_FAIR_EN only).
  - At most one of w_if_gnt and w_d_gnt is high in any cycle.
- RAM side:
  - w_m_addr is the winner's address. It is w_if_addr when no request is granted.
  - w_m_we is w_d_gnt & w_d_we.
  - w_m_din is w_d_wdata, always.
- Response owner register r_own ∈ {NONE, IF, D}:
  - Set to IF on a fetch grant.
  - Set to D on a data read grant.
  - Set to NONE on a data write grant or when nothing is granted.
- Response outputs:
  - w_if_rvalid = (r_own==IF).
  - w_d_rvalid = (r_own==D).
  - Each rdata equals w_m_dout when its rvalid is high, else 0.
- Starve counter r_starve (4 bits):
  - Increments, saturating at STARVE_MAX, when w_if_req is high and w_if_gnt is low.
  - Clears when fetch is granted or when w_if_req is low.
- Starve rule: when r_starve==STARVE_MAX and w_if_req is high, fetch wins and the data request is denied in that cycle.
- Requester protocol:
  - A requester holds req, addr, we and wdata stable until it sees gnt.
  - Dropping req before gnt is allowed; no access occurs in that case.

## Timing
- Grant is in cycle t, same cycle as req, with no added latency. The RAM samples the address and write at the posedge that ends cycle t.
- Read data and rvalid appear in cycle t+1 for exactly one cycle.
- Writes complete at the end of cycle t. No response is returned.
- Throughput is one access per cycle. Back-to-back grants to the same or alternating ports are allowed.
- Read-after-write to the same address in consecutive cycles returns the new data, because the RAM has write-then-read order across cycles.
- Reset values:
  - r_own=NONE, r_starve=0.
  - Both rvalid=0, both rdata=0.
  - While w_rst is high, both gnt=0 and w_m_we=0.
- Reset mid-operation: an in-flight read response is discarded, and no rvalid is seen after reset deasserts. A write granted in the same cycle w_rst rises is suppressed.
- Simultaneous events:
  - Both req with r_starve<STARVE_MAX: data wins.
  - Fetch grant and counter clear take effect in the same edge.

## Configuration
- ARB_FAIR_EN defined:
  - r_starve and the starve rule are compiled in.
  - Fetch waits at most STARVE_MAX denied cycles.
- ARB_FAIR_EN undefined:
  - r_starve is absent and data has strict priority.
  - Fetch can starve indefinitely under continuous data requests.
  - STARVE_MAX is ignored.

## Test plan
- Fetch-only read: preload RAM[5]=0xDEADBEEF. Drive if_req=1 with if_addr=5 in cycle 0.
  - Cycle 0: if_gnt=1.
  - Cycle 1: if_rvalid=1 and if_rdata=0xDEADBEEF, with d_rvalid=0.
- Collision: if_req=1 at addr 3 and d_req=1 read at addr 7 in cycle 0.
  - Cycle 0: d_gnt=1 and if_gnt=0.
  - Cycle 1: d_rvalid with RAM[7], and if_gnt=1.
  - Cycle 2: if_rvalid with RAM[3].
- Write then read: d_req with we=1, addr 9, wdata 0x1234 in cycle 0, then a d read of addr 9 in cycle 1.
  - Cycle 0: no d_rvalid.
  - Cycle 2: d_rvalid with 0x1234.
- Starvation with STARVE_MAX=4: if_req and d_req (reads) held high continuously.
  - With ARB_FAIR_EN: if_gnt=1 in cycle 4 after 4 denied cycles (cycles 0..3), with d_gnt=0 in cycle 4, and the pattern then repeats every 5 cycles.
  - Without ARB_FAIR_EN: if_gnt stays 0 for 50 cycles.
- Async reset mid-read: fetch granted in cycle 0, then w_rst pulsed between edges before cycle 1.
  - if_rvalid=0 immediately and stays 0.
  - Both gnt=0 during reset.
  - Normal grants resume in the first cycle after w_rst falls.
